// File: rtl/rom.sv
// 1024 x 8 read-only lookup table with a registered output.
// Entry A holds ((A[7:0] + 8'h5A) mod 256) XOR {4{A[9:8]}}.
module rom (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] address,
    output logic [7:0] dataout
);

    function automatic logic [7:0] rom_word(input logic [9:0] a);
        logic [7:0] low_sum;
        logic [7:0] pattern;
        low_sum = a[7:0] + 8'h5A;
        pattern = {4{a[9:8]}};
        return low_sum ^ pattern;
    endfunction

    // Every entry is a constant fixed at elaboration, so simulation and synthesis agree
    logic [7:0] table_w [1024];

    for (genvar g = 0; g < 1024; g++) begin : g_table
        assign table_w[g] = rom_word(10'(g));
    end

    logic [7:0] dataout_d;
    logic [7:0] dataout_q;

    always_comb begin
        dataout_d = table_w[address];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dataout_q <= 8'h00;
        end else begin
            dataout_q <= dataout_d;
        end
    end

    assign dataout = dataout_q;

endmodule

// File: tb/tb_rom.sv
// Scoreboard bench for rom: expected words are queued at each sampling edge
// and a negedge monitor pops and compares them against dataout.
module tb_rom;

   logic       clk;
   logic       rst;
   logic [9:0] address;
   logic [7:0] dataout;

   int testsRun;
   int testsFailed;
   logic [7:0] expQueue [$];

   rom dut (
      .clk     (clk),
      .rst     (rst),
      .address (address),
      .dataout (dataout)
   );

   // 20-unit clock period
   initial begin
      clk = 1'b0;
      forever #10 clk = ~clk;
   end

   // Reference model: low byte plus 90 wrapped to a byte, XOR the region index times 0x55
   function automatic logic [7:0] refModel(input int a);
      int low;
      int region;
      low = ((a % 256) + 90) % 256;
      region = a / 256;
      return 8'((low ^ (region * 85)) & 255);
   endfunction

   task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
      testsRun++;
      if (actual !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: dataout=%02h expected=%02h at t=%0t", name, actual, expected, $time);
      end
   endtask

   // Holds the given address for a number of cycles, changing it mid-cycle
   task automatic applyStimulus(input logic [9:0] a, input int cycles);
      repeat (cycles) begin
         @(negedge clk);
         #2 address = a;
      end
   endtask

   // Predictor: every rising edge out of reset loads the word for the sampled address
   initial begin
      forever begin
         @(posedge clk);
         if (rst === 1'b1) expQueue.push_back(refModel(int'(address)));
      end
   end

   // Monitor: the registered output is compared half a cycle after each load
   initial begin
      logic [7:0] expWord;
      forever begin
         @(negedge clk);
         if (expQueue.size() > 0) begin
            expWord = expQueue.pop_front();
            checkOutput("scoreboard", dataout, expWord);
         end
      end
   end

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish, queue=%0d", expQueue.size());
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      testsRun = 0;
      testsFailed = 0;
      rst = 1'b0;
      address = 10'd0;

      // Held in reset with arbitrary addresses
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         #2 address = 10'($urandom_range(0, 1023));
         #1 checkOutput("reset_hold", dataout, 8'h00);
      end

      // Release between edges, output stays clear until the first rising edge
      @(negedge clk);
      #2 address = 10'd700;
      #3 rst = 1'b1;
      #1 checkOutput("release_before_edge", dataout, 8'h00);

      applyStimulus(10'd700, 5);
      @(negedge clk);
      #1 checkOutput("hold_700", dataout, 8'hBC);
      applyStimulus(10'd800, 5);
      @(negedge clk);
      #1 checkOutput("hold_800", dataout, 8'h85);
      applyStimulus(10'd900, 5);
      @(negedge clk);
      #1 checkOutput("hold_900", dataout, 8'h21);

      applyStimulus(10'd0, 2);
      @(negedge clk);
      #1 checkOutput("addr_0", dataout, 8'h5A);
      applyStimulus(10'd1023, 2);
      @(negedge clk);
      #1 checkOutput("addr_1023", dataout, 8'hA6);
      applyStimulus(10'd255, 2);
      @(negedge clk);
      #1 checkOutput("addr_255", dataout, 8'h59);
      applyStimulus(10'd256, 2);
      @(negedge clk);
      #1 checkOutput("addr_256", dataout, 8'h0F);

      // Asynchronous reset in the middle of a read
      applyStimulus(10'd800, 3);
      @(negedge clk);
      #1 checkOutput("before_async_reset", dataout, 8'h85);
      #4 rst = 1'b0;
      #1 checkOutput("async_reset_clears", dataout, 8'h00);
      #2 rst = 1'b1;
      #1 checkOutput("after_release_pending", dataout, 8'h00);
      applyStimulus(10'd800, 2);

      // Exhaustive sweep, one address per cycle
      for (int a = 0; a < 1024; a++) begin
         applyStimulus(10'(a), 1);
      end

      // Random addresses, each held a random number of cycles
      for (int i = 0; i < 200; i++) begin
         applyStimulus(10'($urandom_range(0, 1023)), int'($urandom_range(1, 3)));
      end

      repeat (3) @(negedge clk);
      #1;
      testsRun++;
      if (expQueue.size() != 0) begin
         testsFailed++;
         $display("[TB] FAIL drain: queue=%0d expected=0", expQueue.size());
      end

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
